sc_regir_prefetch: RTL and testbench

//  Parametrised instruction register with a DEPTH-entry prefetch queue.

---
 rtl/sc_regir_prefetch.sv | 130 +++++++++++++
 tb/tb_sc_regir_prefetch.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sc_regir_prefetch.sv
//==============================================================================
// sc_regir_prefetch
//   Instruction register fronted by a DEPTH-entry circular prefetch queue.
//   Fetched words are pushed in from instruction memory. The head entry is the
//   IR value presented to the control unit. Decode consumes the head with
//   Advance, and a taken branch discards the queue with Flush. An occupancy
//   count and a sticky overflow flag are also provided.
//
// Ports
//   SC_RegIRPF_CLOCK_50         in   system clock, rising edge
//   SC_RegIRPF_RESET_InLow      in   asynchronous reset, active-low
//   SC_RegIRPF_Write_InHigh     in   push SC_RegIRPF_DataBUS_In this cycle
//   SC_RegIRPF_DataBUS_In       in   fetched instruction word
//   SC_RegIRPF_Advance_InHigh   in   consume head entry (decode done)
//   SC_RegIRPF_Flush_InHigh     in   discard all entries (has priority)
//   SC_RegIRPF_DataBUS_Out      out  head entry = current IR (registered)
//   SC_RegIRPF_Valid_OutHigh    out  head entry valid (count != 0)
//   SC_RegIRPF_Full_OutHigh     out  count == DEPTH
//   SC_RegIRPF_Count_Out        out  number of entries held
//   SC_RegIRPF_Overflow_OutHigh out  sticky: a push was dropped (reset clears)
//==============================================================================
module sc_regir_prefetch #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int DEPTH         = 4,
    localparam int CNTWIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                     SC_RegIRPF_CLOCK_50,
    input  logic                     SC_RegIRPF_RESET_InLow,
    input  logic                     SC_RegIRPF_Write_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegIRPF_DataBUS_In,
    input  logic                     SC_RegIRPF_Advance_InHigh,
    input  logic                     SC_RegIRPF_Flush_InHigh,
    output logic [DATAWIDTH_BUS-1:0] SC_RegIRPF_DataBUS_Out,
    output logic                     SC_RegIRPF_Valid_OutHigh,
    output logic                     SC_RegIRPF_Full_OutHigh,
    output logic [CNTWIDTH-1:0]      SC_RegIRPF_Count_Out,
    output logic                     SC_RegIRPF_Overflow_OutHigh
);

    localparam int PTRWIDTH = $clog2(DEPTH);
    localparam logic [CNTWIDTH-1:0] FULLCOUNT = CNTWIDTH'(DEPTH);

    logic [DATAWIDTH_BUS-1:0] queueMem [DEPTH];

    logic [PTRWIDTH-1:0]      wrPtr,      rdPtr;
    logic [CNTWIDTH-1:0]      countReg;
    logic [DATAWIDTH_BUS-1:0] headReg;
    logic                     validReg,   fullReg,   overflowReg;

    logic                     pushOk,     advOk;
    logic [PTRWIDTH-1:0]      wrPtrNext,  rdPtrNext;
    logic [CNTWIDTH-1:0]      countNext;
    logic [DATAWIDTH_BUS-1:0] headNext;
    logic                     overflowNext;

    // A push is accepted when there is room, or when a full queue frees a slot
    // by advancing in the same cycle.
    assign advOk  = SC_RegIRPF_Advance_InHigh & validReg;
    assign pushOk = SC_RegIRPF_Write_InHigh & (~fullReg | advOk);

    always_comb begin
        wrPtrNext    = wrPtr;
        rdPtrNext    = rdPtr;
        countNext    = countReg;
        headNext     = headReg;
        overflowNext = overflowReg;
        if (SC_RegIRPF_Flush_InHigh) begin
            // Flush discards everything; overflow stays sticky and the stale
            // head word is left on the bus (consumers ignore it while invalid).
            wrPtrNext = '0;
            rdPtrNext = '0;
            countNext = '0;
        end else begin
            if (pushOk)
                wrPtrNext = wrPtr + PTRWIDTH'(1);
            if (advOk)
                rdPtrNext = rdPtr + PTRWIDTH'(1);
            case ({pushOk, advOk})
                2'b10:   countNext = countReg + CNTWIDTH'(1);
                2'b01:   countNext = countReg - CNTWIDTH'(1);
                default: countNext = countReg;
            endcase
            if (SC_RegIRPF_Write_InHigh & fullReg & ~advOk)
                overflowNext = 1'b1;
            // The registered head is the entry at the new read pointer. When
            // the word being pushed lands exactly there (queue empty, or one
            // entry being replaced), it is not yet in memory, so bypass it.
            if (countNext != '0) begin
                if (pushOk && (wrPtr == rdPtrNext))
                    headNext = SC_RegIRPF_DataBUS_In;
                else
                    headNext = queueMem[rdPtrNext];
            end
        end
    end

    // Storage array: data only, never reset.
    always_ff @(posedge SC_RegIRPF_CLOCK_50) begin
        if (pushOk && !SC_RegIRPF_Flush_InHigh)
            queueMem[wrPtr] <= SC_RegIRPF_DataBUS_In;
    end

    // ---- State and registered outputs ----
    always_ff @(posedge SC_RegIRPF_CLOCK_50 or negedge SC_RegIRPF_RESET_InLow) begin
        if (!SC_RegIRPF_RESET_InLow) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            countReg    <= '0;
            headReg     <= '0;
            validReg    <= 1'b0;
            fullReg     <= 1'b0;
            overflowReg <= 1'b0;
        end else begin
            wrPtr       <= wrPtrNext;
            rdPtr       <= rdPtrNext;
            countReg    <= countNext;
            headReg     <= headNext;
            validReg    <= (countNext != '0);
            fullReg     <= (countNext == FULLCOUNT);
            overflowReg <= overflowNext;
        end
    end

    assign SC_RegIRPF_DataBUS_Out      = headReg;
    assign SC_RegIRPF_Valid_OutHigh    = validReg;
    assign SC_RegIRPF_Full_OutHigh     = fullReg;
    assign SC_RegIRPF_Count_Out        = countReg;
    assign SC_RegIRPF_Overflow_OutHigh = overflowReg;

endmodule

// File: tb/tb_sc_regir_prefetch.sv
//==============================================================================
// tb_sc_regir_prefetch
//   Directed bench for sc_regir_prefetch (DATAWIDTH_BUS=32, DEPTH=4). Inputs
//   change and outputs are sampled 1 ns after the rising clock edge.
//==============================================================================
module tb_sc_regir_prefetch;

    logic        clk;
    logic        rstN;
    logic        writeEn;
    logic [31:0] dataIn;
    logic        advance;
    logic        flush;
    logic [31:0] dataOut;
    logic        validOut;
    logic        fullOut;
    logic [2:0]  countOut;
    logic        overflowOut;

    int checkCount;
    int errorCount;

    sc_regir_prefetch #(
        .DATAWIDTH_BUS(32),
        .DEPTH(4)
    ) dut (
        .SC_RegIRPF_CLOCK_50        (clk),
        .SC_RegIRPF_RESET_InLow     (rstN),
        .SC_RegIRPF_Write_InHigh    (writeEn),
        .SC_RegIRPF_DataBUS_In      (dataIn),
        .SC_RegIRPF_Advance_InHigh  (advance),
        .SC_RegIRPF_Flush_InHigh    (flush),
        .SC_RegIRPF_DataBUS_Out     (dataOut),
        .SC_RegIRPF_Valid_OutHigh   (validOut),
        .SC_RegIRPF_Full_OutHigh    (fullOut),
        .SC_RegIRPF_Count_Out       (countOut),
        .SC_RegIRPF_Overflow_OutHigh(overflowOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One clock with the given inputs, then inputs return to idle.
    task automatic cycle(input logic w, input logic [31:0] d, input logic a,
                         input logic f);
        writeEn = w;
        dataIn  = d;
        advance = a;
        flush   = f;
        @(posedge clk);
        #1;
        writeEn = 1'b0;
        advance = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic pushWord(input logic [31:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    // Check head, then consume it.
    task automatic popExpect(input string tag, input logic [31:0] expected);
        checkValue(tag, dataOut, expected);
        checkValue({tag, "_valid"}, {31'd0, validOut}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic fillA(input string tag);
        for (int i = 0; i < 4; i++) begin
            pushWord(32'hA0 + 32'(i));
            checkValue({tag, "_cnt"}, {29'd0, countOut}, 32'(i + 1));
        end
        checkValue({tag, "_full"}, {31'd0, fullOut}, 32'd1);
        checkValue({tag, "_head"}, dataOut, 32'hA0);
    endtask

    task automatic checkEmpty(input string tag);
        checkValue({tag, "_cnt"},   {29'd0, countOut}, 32'd0);
        checkValue({tag, "_valid"}, {31'd0, validOut}, 32'd0);
        checkValue({tag, "_full"},  {31'd0, fullOut},  32'd0);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        writeEn = 1'b0;
        dataIn  = 32'h0;
        advance = 1'b0;
        flush   = 1'b0;
        rstN    = 1'b0;
        #2;
        checkValue("por_out", dataOut, 32'h0);
        checkValue("por_ovf", {31'd0, overflowOut}, 32'd0);
        checkEmpty("por");
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Advance on an empty queue is ignored without error.
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        checkEmpty("advEmpty");
        checkValue("advEmpty_ovf", {31'd0, overflowOut}, 32'd0);

        // Fill and drain.
        pushWord(32'hA0);
        checkValue("lat1_out", dataOut, 32'hA0);
        checkValue("lat1_valid", {31'd0, validOut}, 32'd1);
        for (int i = 1; i < 4; i++) pushWord(32'hA0 + 32'(i));
        checkValue("fill_cnt", {29'd0, countOut}, 32'd4);
        checkValue("fill_full", {31'd0, fullOut}, 32'd1);
        for (int i = 0; i < 4; i++) popExpect("drain", 32'hA0 + 32'(i));
        checkEmpty("drained");

        // Overflow: push into a full queue without advance is dropped.
        fillA("ovfFill");
        pushWord(32'hBB);
        checkValue("ovf_flag", {31'd0, overflowOut}, 32'd1);
        checkValue("ovf_cnt", {29'd0, countOut}, 32'd4);
        checkValue("ovf_head", dataOut, 32'hA0);
        for (int i = 0; i < 4; i++) popExpect("ovfDrain", 32'hA0 + 32'(i));
        checkEmpty("ovfDrained");
        checkValue("ovf_sticky", {31'd0, overflowOut}, 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkValue("ovf_afterFlush", {31'd0, overflowOut}, 32'd1);

        // Asynchronous reset mid-stream with three entries held.
        pushWord(32'h31);
        pushWord(32'h32);
        pushWord(32'h33);
        checkValue("pre_rst_cnt", {29'd0, countOut}, 32'd3);
        #2;
        rstN = 1'b0;
        #1;
        checkEmpty("rst");
        checkValue("rst_out", dataOut, 32'h0);
        checkValue("rst_ovf", {31'd0, overflowOut}, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checkEmpty("postRst");

        // Push and advance together on a full queue.
        fillA("paFill");
        cycle(1'b1, 32'hC4, 1'b1, 1'b0);
        checkValue("pa_head", dataOut, 32'hA1);
        checkValue("pa_cnt", {29'd0, countOut}, 32'd4);
        checkValue("pa_full", {31'd0, fullOut}, 32'd1);
        checkValue("pa_ovf", {31'd0, overflowOut}, 32'd0);
        popExpect("paDrain0", 32'hA1);
        popExpect("paDrain1", 32'hA2);
        popExpect("paDrain2", 32'hA3);
        popExpect("paDrain3", 32'hC4);
        checkEmpty("paDrained");

        // Flush beats simultaneous write and advance.
        pushWord(32'h11);
        pushWord(32'h22);
        cycle(1'b1, 32'hDD, 1'b1, 1'b1);
        checkEmpty("flush");
        pushWord(32'hEE);
        checkValue("flush_next", dataOut, 32'hEE);
        checkValue("flush_next_cnt", {29'd0, countOut}, 32'd1);
        popExpect("flushDrain", 32'hEE);
        checkEmpty("flushDrained");

        // Ten push/advance pairs at count=1 wrap both pointers.
        pushWord(32'h100);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
            checkValue("wrap_head", dataOut, 32'h200 + 32'(i));
            checkValue("wrap_cnt", {29'd0, countOut}, 32'd1);
        end
        popExpect("wrapLast", 32'h209);
        checkEmpty("wrapDrained");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
